// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter and command sequencer in front of the SDRAM controller.
// Outstanding reads are tagged in an in-order FIFO so returned data reaches its requester.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            p0_req,
  input  logic                            p0_wr,
  input  logic [ADDR_WIDTH-1:0]           p0_addr,
  input  logic [DATA_WIDTH-1:0]           p0_wdata,
  input  logic [1:0]                      p0_be_n,
  output logic                            p0_ack,
  output logic [DATA_WIDTH-1:0]           p0_rdata,
  output logic                            p0_rvalid,
  input  logic                            p1_req,
  input  logic                            p1_wr,
  input  logic [ADDR_WIDTH-1:0]           p1_addr,
  input  logic [DATA_WIDTH-1:0]           p1_wdata,
  input  logic [1:0]                      p1_be_n,
  output logic                            p1_ack,
  output logic [DATA_WIDTH-1:0]           p1_rdata,
  output logic                            p1_rvalid,
  output logic [ADDR_WIDTH-1:0]           az_addr,
  output logic [1:0]                      az_be_n,
  output logic [DATA_WIDTH-1:0]           az_data,
  output logic                            az_cs,
  output logic                            az_rd_n,
  output logic                            az_wr_n,
  input  logic [DATA_WIDTH-1:0]           za_data,
  input  logic                            za_valid,
  input  logic                            za_waitrequest,
  output logic [$clog2(MAX_PENDING):0]    pending,
  output logic                            tag_underflow
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, next_state;
  logic             grant, last_grant;
  logic             p0_elig, p1_elig, any_elig, winner, win_wr;
  logic             accept, push, pop, head_tag;
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic [MAX_PENDING-1:0] tag_mem;

  assign az_cs   = 1'b1;
  assign pending = wr_ptr - rd_ptr;

  // A full tag FIFO only blocks reads; writes never produce a return.
  assign p0_elig  = p0_req && (p0_wr || (pending < CNT_W'(MAX_PENDING)));
  assign p1_elig  = p1_req && (p1_wr || (pending < CNT_W'(MAX_PENDING)));
  assign any_elig = p0_elig || p1_elig;
  assign winner   = (p0_elig && p1_elig) ? ~last_grant : p1_elig;
  assign win_wr   = winner ? p1_wr : p0_wr;

  assign accept   = (state == ISSUE) && !za_waitrequest;
  assign push     = accept && !az_rd_n;
  assign pop      = za_valid && (pending != '0);
  assign head_tag = tag_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_elig) next_state = ISSUE;
      ISSUE:   if (!za_waitrequest) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    if (accept) begin
      p0_ack = (grant == 1'b0);
      p1_ack = (grant == 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      az_addr    <= '0;
      az_be_n    <= '0;
      az_data    <= '0;
      az_rd_n    <= 1'b1;
      az_wr_n    <= 1'b1;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if ((state == IDLE) && any_elig) begin
      grant   <= winner;
      az_addr <= winner ? p1_addr  : p0_addr;
      az_data <= winner ? p1_wdata : p0_wdata;
      az_be_n <= winner ? p1_be_n  : p0_be_n;
      az_rd_n <= win_wr;
      az_wr_n <= !win_wr;
    end else if (accept) begin
      az_rd_n    <= 1'b1;
      az_wr_n    <= 1'b1;
      last_grant <= grant;
    end
  end

  // Tag FIFO: pointers carry an extra MSB so full and empty differ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tag_mem       <= '0;
      tag_underflow <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr[PTR_W-1:0]] <= grant;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (za_valid && (pending == '0)) tag_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= pop && !head_tag;
      p1_rvalid <= pop && head_tag;
      if (pop && !head_tag) p0_rdata <= za_data;
      if (pop && head_tag)  p1_rdata <= za_data;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1-2ns after it.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [21:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_be_n, p1_be_n;
  logic        p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_cs, az_rd_n, az_wr_n;
  logic [15:0] za_data;
  logic        za_valid, za_waitrequest;
  logic [2:0]  pending;
  logic        tag_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_WIDTH(22), .DATA_WIDTH(16), .MAX_PENDING(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be_n(p0_be_n), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be_n(p1_be_n), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .az_addr(az_addr), .az_be_n(az_be_n), .az_data(az_data), .az_cs(az_cs),
    .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest),
    .pending(pending), .tag_underflow(tag_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Presents one command, waits (bounded) for its ack, then drops the request.
  task automatic applyStimulus(input string tag, input int port, input logic wr,
                               input logic [21:0] addr, input logic [15:0] wdata);
    logic seen;
    seen = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_wr = wr; p0_addr = addr; p0_wdata = wdata; p0_be_n = 2'b00;
    end else begin
      p1_req = 1'b1; p1_wr = wr; p1_addr = addr; p1_wdata = wdata; p1_be_n = 2'b00;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port == 0) ? p0_ack : p1_ack) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_ack"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_addr"}, 32'(az_addr), 32'(addr));
      checkOutput({tag, "_rd_n"}, 32'(az_rd_n), 32'(wr));
    end
    step();
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  int          grants[4];
  int          ngrant;
  int          exp_port[3];
  logic        ack_seen;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0; p0_be_n = '0;
    p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0; p1_be_n = '0;
    za_data = '0; za_valid = 0; za_waitrequest = 0;

    applyReset();
    repeat (2) step();
    checkOutput("rst_rd_n", 32'(az_rd_n), 32'd1);
    checkOutput("rst_wr_n", 32'(az_wr_n), 32'd1);
    checkOutput("rst_cs", 32'(az_cs), 32'd1);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_addr", 32'(az_addr), 32'd0);
    checkOutput("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    checkOutput("rst_underflow", 32'(tag_underflow), 32'd0);

    // Single write held off by three waitrequest cycles.
    p0_req = 1; p0_wr = 1; p0_addr = 22'h000010; p0_wdata = 16'h00AB; p0_be_n = 2'b00;
    za_waitrequest = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      za_waitrequest = (i < 3);
      #1;
      checkOutput("wr_wr_n_low", 32'(az_wr_n), 32'd0);
      checkOutput("wr_addr", 32'(az_addr), 32'h10);
      checkOutput("wr_data", 32'(az_data), 32'hAB);
      checkOutput("wr_ack", 32'(p0_ack), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    p0_req = 0;
    #1;
    checkOutput("wr_done_wr_n", 32'(az_wr_n), 32'd1);
    checkOutput("wr_done_ack", 32'(p0_ack), 32'd0);

    // Contention: both ports read continuously, grants alternate from p0.
    applyReset();
    p0_req = 1; p0_wr = 0; p0_addr = 22'h1;
    p1_req = 1; p1_wr = 0; p1_addr = 22'h2;
    ngrant = 0;
    for (int c = 0; c < 20 && ngrant < 4; c++) begin
      @(posedge clk);
      #2;
      if (p0_ack || p1_ack) begin
        grants[ngrant] = p1_ack ? 1 : 0;
        checkOutput("cont_addr", 32'(az_addr), p1_ack ? 32'h2 : 32'h1);
        ngrant++;
      end
    end
    checkOutput("cont_ngrant", 32'(ngrant), 32'd4);
    for (int g = 0; g < 4; g++)
      checkOutput("cont_grant", 32'(grants[g]), 32'(g % 2));
    step();
    p0_req = 0; p1_req = 0;
    checkOutput("full_pending", 32'(pending), 32'd4);

    // FIFO full: a read stalls but a write still goes through.
    p1_req = 1; p1_wr = 0; p1_addr = 22'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("full_rd_stall", 32'(az_rd_n), 32'd1);
      checkOutput("full_no_ack", 32'(p1_ack), 32'd0);
    end
    applyStimulus("full_wr", 0, 1'b1, 22'h20, 16'h0055);
    checkOutput("full_wr_pending", 32'(pending), 32'd4);

    za_valid = 1; za_data = 16'hAAAA;
    step();
    za_valid = 0;
    checkOutput("pop_p0_rvalid", 32'(p0_rvalid), 32'd1);
    checkOutput("pop_p0_rdata", 32'(p0_rdata), 32'hAAAA);
    checkOutput("pop_p1_quiet", 32'(p1_rvalid), 32'd0);
    checkOutput("pop_pending", 32'(pending), 32'd3);
    checkOutput("pop_not_yet", 32'(az_rd_n), 32'd1);
    step();
    checkOutput("unstall_rd_n", 32'(az_rd_n), 32'd0);
    checkOutput("unstall_addr", 32'(az_addr), 32'h7);
    za_valid = 1; za_data = 16'hBBBB;
    #1;
    checkOutput("unstall_ack", 32'(p1_ack), 32'd1);
    step();
    za_valid = 0; p1_req = 0;
    checkOutput("pushpop_pending", 32'(pending), 32'd3);
    checkOutput("pushpop_p1_rvalid", 32'(p1_rvalid), 32'd1);
    checkOutput("pushpop_p1_rdata", 32'(p1_rdata), 32'hBBBB);
    checkOutput("pushpop_p0_quiet", 32'(p0_rvalid), 32'd0);

    // Drain the remaining tags: p0, p1, p1 in issue order.
    exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 1;
    for (int i = 0; i < 3; i++) begin
      za_valid = 1; za_data = 16'h3000 + 16'(i);
      step();
      checkOutput("drain_p0_rvalid", 32'(p0_rvalid), (exp_port[i] == 0) ? 32'd1 : 32'd0);
      checkOutput("drain_p1_rvalid", 32'(p1_rvalid), (exp_port[i] == 1) ? 32'd1 : 32'd0);
      checkOutput("drain_rdata", (exp_port[i] == 0) ? 32'(p0_rdata) : 32'(p1_rdata), 32'h3000 + 32'(i));
      checkOutput("drain_pending", 32'(pending), 32'(2 - i));
    end
    za_valid = 0;

    // Read return routing: p1 read then p0 read.
    applyStimulus("route_p1", 1, 1'b0, 22'h5, 16'h0);
    applyStimulus("route_p0", 0, 1'b0, 22'h9, 16'h0);
    checkOutput("route_pending", 32'(pending), 32'd2);
    za_valid = 1; za_data = 16'h1111;
    step();
    checkOutput("route_first_p1", 32'({p1_rvalid, p0_rvalid}), 32'b10);
    checkOutput("route_first_data", 32'(p1_rdata), 32'h1111);
    za_data = 16'h2222;
    step();
    za_valid = 0;
    checkOutput("route_second_p0", 32'({p1_rvalid, p0_rvalid}), 32'b01);
    checkOutput("route_second_data", 32'(p0_rdata), 32'h2222);
    step();
    checkOutput("route_rvalid_1cyc", 32'({p1_rvalid, p0_rvalid}), 32'b00);
    checkOutput("route_pending_0", 32'(pending), 32'd0);

    // Spurious return with nothing outstanding.
    za_valid = 1; za_data = 16'hDEAD;
    step();
    za_valid = 0;
    checkOutput("spur_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'b00);
    checkOutput("spur_underflow", 32'(tag_underflow), 32'd1);
    checkOutput("spur_pending", 32'(pending), 32'd0);
    repeat (3) step();
    checkOutput("spur_sticky", 32'(tag_underflow), 32'd1);

    // Reset asserted in the middle of an ISSUE.
    za_waitrequest = 1;
    p0_req = 1; p0_wr = 1; p0_addr = 22'h30; p0_wdata = 16'h0077;
    step();
    checkOutput("midrst_issue", 32'(az_wr_n), 32'd0);
    #2;
    reset_n = 0;
    #1;
    checkOutput("midrst_wr_n", 32'(az_wr_n), 32'd1);
    checkOutput("midrst_rd_n", 32'(az_rd_n), 32'd1);
    checkOutput("midrst_underflow", 32'(tag_underflow), 32'd0);
    za_waitrequest = 0;
    #1;
    checkOutput("midrst_no_ack", 32'(p0_ack), 32'd0);
    p0_req = 0;
    step();
    reset_n = 1;
    za_valid = 1; za_data = 16'h4444;
    step();
    za_valid = 0;
    checkOutput("postrst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'b00);
    checkOutput("postrst_underflow", 32'(tag_underflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
